// File: rtl/disp_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-synchronous digit shadow registers.
// Define DISP_SCAN_BLANK_EN to add an anti-ghosting dead-time (BLANK) at the end of every slot.
module disp_scan_ctrl #(
  parameter int CLK_FREQUENCY  = 10_000_000,
  parameter int SCAN_FREQUENCY = 240,
  parameter int NUM_DIGITS     = 4,
  parameter int BLANK_CYCLES   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [$clog2(NUM_DIGITS)-1:0] wr_addr,
  input  logic [3:0]                    wr_data,
  input  logic [NUM_DIGITS-1:0]         digit_en_mask,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    seg,
  output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
  output logic                          frame_start
);

  localparam int STEP = CLK_FREQUENCY / (SCAN_FREQUENCY * NUM_DIGITS);
  localparam int AW   = $clog2(NUM_DIGITS);
  localparam int CW   = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(STEP - 1);
  localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);
  localparam logic [AW:0]   ADDR_LIMIT = (AW + 1)'(NUM_DIGITS);

  if (BLANK_CYCLES >= STEP || NUM_DIGITS < 2) begin : g_param_check
    $error("disp_scan_ctrl: need NUM_DIGITS >= 2 and BLANK_CYCLES < STEP");
  end

`ifdef DISP_SCAN_BLANK_EN
  localparam logic [CW-1:0] SHOW_LAST = CW'(STEP - BLANK_CYCLES - 1);
  typedef enum logic [0:0] { SHOW, BLANK } state_t;
`else
  typedef enum logic [0:0] { SHOW } state_t;
`endif

  state_t          state;
  state_t          next_state;
  logic            started;
  logic [CW-1:0]   slot_cnt;
  logic [CW-1:0]   next_cnt;
  logic [AW-1:0]   next_idx;
  logic            slot_last;
  logic            commit_now;
  logic            next_frame;
  logic            next_commit;
  logic            wr_accept;
  logic [3:0]      next_digit;
  logic [3:0]      shadow [NUM_DIGITS];
  logic [3:0]      active [NUM_DIGITS];

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Registers describe the cycle currently on the pins; this computes the cycle about to start.
  // `started` lets the first edge after reset land on slot 0 cycle 0 rather than cycle 1.
  always_comb begin
    slot_last  = started && (slot_cnt == CNT_LAST);
    commit_now = slot_last && (scan_idx == IDX_LAST);
    next_cnt   = slot_cnt + 1'b1;
    next_idx   = scan_idx;
    if (!started) begin
      next_cnt = '0;
      next_idx = '0;
    end else if (slot_last) begin
      next_cnt = '0;
      next_idx = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end
    next_frame  = !started || commit_now;
    next_commit = (next_idx == IDX_LAST) && (next_cnt == CNT_LAST);

    next_state = state;
`ifdef DISP_SCAN_BLANK_EN
    case (state)
      SHOW:    if (started && slot_cnt == SHOW_LAST) next_state = BLANK;
      BLANK:   if (slot_last) next_state = SHOW;
      default: next_state = SHOW;
    endcase
`endif

    // Digit 0 of a new frame must see the value being committed on this same edge.
    next_digit = commit_now ? shadow[next_idx] : active[next_idx];
    wr_accept  = wr_valid && wr_ready && ({1'b0, wr_addr} < ADDR_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      started     <= 1'b0;
      slot_cnt    <= '0;
      scan_idx    <= '0;
      state       <= SHOW;
      an          <= '1;
      seg         <= 7'b1111111;
      frame_start <= 1'b0;
      wr_ready    <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow[i] <= 4'h0;
        active[i] <= 4'h0;
      end
    end else begin
      started     <= 1'b1;
      slot_cnt    <= next_cnt;
      scan_idx    <= next_idx;
      state       <= next_state;
      frame_start <= next_frame;
      wr_ready    <= !next_commit;

      if (commit_now) begin
        for (int i = 0; i < NUM_DIGITS; i++) active[i] <= shadow[i];
      end
      if (wr_accept) shadow[wr_addr] <= wr_data;

      if (next_state == SHOW) begin
        an  <= digit_en_mask[next_idx] ? ~(NUM_DIGITS'(1) << next_idx) : '1;
        seg <= decode(next_digit);
      end else begin
        an  <= '1;
        seg <= 7'b1111111;
      end
    end
  end

endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan controller for the multiplexed 7-segment display. It generates the per-digit time slots from the system clock, drives the active-low anode and segment lines, and decodes a 4-bit hex nibble per digit. Writers update digit values through a valid/ready port into shadow registers. Shadow contents reach the display only at frame boundaries, so a frame never shows a partial update.

## Interface
- CLK_FREQUENCY, 10_000_000, input clock frequency in Hz
- SCAN_FREQUENCY, 240, full-frame refresh rate in Hz (all digits once per frame)
- NUM_DIGITS, 4, number of digits scanned (≥2)
- BLANK_CYCLES, 16, dead-time per slot, used only with blanking compiled in (< STEP)
- STEP (localparam) = CLK_FREQUENCY / (SCAN_FREQUENCY*NUM_DIGITS), clock cycles per digit slot
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when high with wr_valid
- wr_addr  in  $clog2(NUM_DIGITS)  target digit
- wr_data  in  4  hex nibble
- digit_en_mask  in  NUM_DIGITS  bit i=0 keeps digit i dark in its slot
- an  out  NUM_DIGITS  anode drive, active-low, one-hot-low when lit
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- scan_idx  out  $clog2(NUM_DIGITS)  digit currently owning the slot
- frame_start  out  1  one-cycle pulse on first cycle of digit 0 slot

One clock; reset is synchronous and active-high (clk, rst).

## Operation
- Reset values: an all 1s, seg 7'b1111111, scan_idx 0, frame_start 0, wr_ready 0, shadow and active registers 0, slot counter 0, state SHOW.
- States: SHOW, BLANK (BLANK exists only with macro).
- SHOW:
  - an[scan_idx]=0 if digit_en_mask[scan_idx], else all 1s.
  - seg = decode(active[scan_idx]).
  - Lasts STEP cycles (STEP−BLANK_CYCLES with macro).
- BLANK: an all 1s, seg all 1s, lasts BLANK_CYCLES. Then advance.
- Advance: scan_idx ← scan_idx+1, wrapping NUM_DIGITS−1 → 0.
- Wrap to 0 is the frame boundary:
  - active ← shadow (all digits, same cycle).
  - frame_start pulses.
- Decode (active-low): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- Writes:
  - wr_valid&&wr_ready → shadow[wr_addr] ← wr_data.
  - wr_addr ≥ NUM_DIGITS is accepted and discarded.
  - wr_ready=1 every cycle except rst cycles and the commit cycle.
  - A write presented during the commit cycle stalls one cycle and lands in the next frame.
- Multiple writes to one digit within a frame: last accepted wins.
- digit_en_mask is sampled every cycle, is not frame-synchronised, and never alters slot timing.
- rst mid-frame: immediate return to reset values. Shadow is cleared, and pending writes are lost.

## Timing
- All outputs registered.
- First cycle after rst deasserts:
  - scan_idx=0, slot 0 lit (an=…1110 if mask bit 0).
  - frame_start=1.
  - seg shows decode(0)=1000000.
  - wr_ready=1.
- Slot period exactly STEP cycles in both configurations. Frame period NUM_DIGITS*STEP cycles.
- Write-to-display latency: from acceptance to the next frame boundary, 1 to NUM_DIGITS*STEP cycles.
- Commit cycle is the last cycle of digit NUM_DIGITS−1 slot. active updates on that edge and is visible in the first cycle of digit 0 slot.
- Counters: slot counter width $clog2(STEP), compare at STEP−1, no overflow.

## Configuration
- Macro DISP_SCAN_BLANK_EN.
- Defined: each slot is SHOW for STEP−BLANK_CYCLES cycles, then BLANK for BLANK_CYCLES cycles with all lines off. This is the anti-ghosting dead-time.
- Undefined: no BLANK state. SHOW lasts the full STEP cycles, and anodes switch directly between digits.

## Test plan
Bench parameters: CLK_FREQUENCY=1000, SCAN_FREQUENCY=25, NUM_DIGITS=4 (STEP=10), BLANK_CYCLES=3.
- Reset release:
  - Cycle 1: an=1110, seg=1000000, frame_start=1.
  - an=1101 at cycle 11.
  - frame_start next pulses at cycle 41.
- Frame-synchronous update:
  - Write addr=2 data=0xA at cycle 5.
  - seg stays 1000000 in slot 2 of frame 0.
  - From cycle 41, slot 2 (cycles 61–70) shows an=1011, seg=0001000.
- Commit-cycle collision:
  - wr_valid held at cycle 40.
  - wr_ready=0 at 40, accepted at 41.
  - Value appears only in the frame starting at cycle 81.
- Mask:
  - digit_en_mask=1011 (digit 2 off).
  - an all 1s during cycles 21–30; other slots unchanged, period still 10.
- Blanking (DISP_SCAN_BLANK_EN defined):
  - In slot 0, an=1110 for cycles 1–7.
  - an=1111 and seg=1111111 for cycles 8–10.
  - Without the macro, an=1110 for cycles 1–10.
- Mid-frame reset:
  - Assert rst at cycle 25 for 2 cycles, after writing 8 to all digits.
  - Outputs return to reset values.
  - After release, scan restarts at digit 0 with seg=1000000.
